// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: button edge detect, move legality, move queue and IDLE/RUN state.
// Optional PAUSE_KEY_EN adds a btn_pause input that toggles the paused state while running.
module snake_dir_ctrl #(
    parameter int         DEPTH    = 2,
    parameter logic [1:0] INIT_DIR = 2'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
`ifdef PAUSE_KEY_EN
    input  logic       btn_pause,
`endif
    input  logic       tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       dir_changed,
    output logic       running,
    output logic [2:0] queue_count,
    output logic       overflow,
    output logic       paused
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_rptr, r_wptr, w_tail_idx;
    logic [2:0]      r_count;
    logic [1:0]      r_dir;
    logic            r_dir_changed, r_overflow;
    logic [3:0]      r_prev;
    logic            r_arm;
    logic [3:0]      w_btn, w_rise;
    logic            w_cand_vld;
    logic [1:0]      w_cand, w_ref;
    logic            w_legal, w_full, w_pop, w_try, w_push, w_ovf, w_paused;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // r_arm masks the first cycle out of reset so a held button is not seen as a press
    assign w_btn  = {btn_up, btn_right, btn_down, btn_left};
    assign w_rise = r_arm ? (w_btn & ~r_prev) : 4'b0000;

    always_comb begin
        w_cand_vld = 1'b1;
        w_cand     = 2'd0;
        if      (w_rise[3]) w_cand = 2'd0;
        else if (w_rise[2]) w_cand = 2'd1;
        else if (w_rise[1]) w_cand = 2'd2;
        else if (w_rise[0]) w_cand = 2'd3;
        else                w_cand_vld = 1'b0;
    end

    assign w_tail_idx = (r_wptr == '0) ? PW'(DEPTH - 1) : r_wptr - PW'(1);
    assign w_ref      = (r_count != 3'd0) ? r_mem[w_tail_idx] : r_dir;
    assign w_legal    = w_cand_vld && (w_cand != w_ref) && (w_cand != (w_ref ^ 2'd2));
    assign w_full     = (r_count == 3'(DEPTH));
    assign w_pop      = tick && (r_state == S_RUN) && (r_count != 3'd0) && !w_paused;
    assign w_try      = w_legal && !w_paused;
    // a pop in the same cycle frees a slot, so a full queue plus tick is not an overflow
    assign w_push     = w_try && (!w_full || w_pop);
    assign w_ovf      = w_try && w_full && !w_pop;

    always_comb begin
        w_state_nxt = r_state;
        if (game_over)                        w_state_nxt = S_IDLE;
        else if (r_state == S_IDLE && w_push) w_state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev        <= 4'b0000;
            r_arm         <= 1'b0;
            r_rptr        <= '0;
            r_wptr        <= '0;
            r_count       <= 3'd0;
            r_dir         <= INIT_DIR;
            r_dir_changed <= 1'b0;
            r_overflow    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'd0;
        end else begin
            r_prev <= w_btn;
            r_arm  <= 1'b1;
            if (game_over) begin
                r_rptr        <= '0;
                r_wptr        <= '0;
                r_count       <= 3'd0;
                r_dir         <= INIT_DIR;
                r_dir_changed <= 1'b0;
                r_overflow    <= 1'b0;
            end else begin
                r_dir_changed <= w_pop;
                r_overflow    <= w_ovf;
                if (w_pop) begin
                    r_dir  <= r_mem[r_rptr];
                    r_rptr <= ptr_inc(r_rptr);
                end
                if (w_push) begin
                    r_mem[r_wptr] <= w_cand;
                    r_wptr        <= ptr_inc(r_wptr);
                end
                if (w_push && !w_pop)      r_count <= r_count + 3'd1;
                else if (!w_push && w_pop) r_count <= r_count - 3'd1;
            end
        end
    end

`ifdef PAUSE_KEY_EN
    logic r_pause_prev, r_paused;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pause_prev <= 1'b0;
            r_paused     <= 1'b0;
        end else begin
            r_pause_prev <= btn_pause;
            if (game_over)
                r_paused <= 1'b0;
            else if (r_arm && btn_pause && !r_pause_prev && r_state == S_RUN)
                r_paused <= ~r_paused;
        end
    end
    assign w_paused = r_paused;
`else
    assign w_paused = 1'b0;
`endif

    assign dir         = r_dir;
    assign dir_changed = r_dir_changed;
    assign running     = (r_state == S_RUN);
    assign queue_count = r_count;
    assign overflow    = r_overflow;
    assign paused      = w_paused;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl (DEPTH=2, INIT_DIR=1).
// Pause scenarios are compiled in only when PAUSE_KEY_EN is defined.
module tb_snake_dir_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_right, btn_down, btn_left;
    logic       btn_pause;
    logic       tick, game_over;
    logic [1:0] dir;
    logic       dir_changed, running, overflow, paused;
    logic [2:0] queue_count;
    int         n_cmp = 0;
    int         n_bad = 0;

    snake_dir_ctrl #(.DEPTH(2), .INIT_DIR(2'd1)) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down), .btn_left(btn_left),
`ifdef PAUSE_KEY_EN
        .btn_pause(btn_pause),
`endif
        .tick(tick), .game_over(game_over),
        .dir(dir), .dir_changed(dir_changed), .running(running),
        .queue_count(queue_count), .overflow(overflow), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // 0 up, 1 right, 2 down, 3 left: one-cycle high then one-cycle low
    task automatic press(input int b);
        case (b)
            0: btn_up = 1'b1;
            1: btn_right = 1'b1;
            2: btn_down = 1'b1;
            default: btn_left = 1'b1;
        endcase
        cyc();
        btn_up = 1'b0; btn_right = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
        cyc();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; game_over = 1'b0; btn_pause = 1'b0;
        btn_up = 1'b1; btn_right = 1'b1; btn_down = 1'b0; btn_left = 1'b0;
        cyc(); cyc();
        chk("rst_dir", dir, 1);
        chk("rst_running", running, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_dc", dir_changed, 0);
        chk("rst_paused", paused, 0);
        reset = 1'b0;
        cyc(); cyc();
        chk("held_count", queue_count, 0);
        chk("held_running", running, 0);
        btn_up = 1'b0; btn_right = 1'b0;
        cyc();

        press(1);
        chk("same_dir_idle_count", queue_count, 0);
        chk("same_dir_idle_running", running, 0);
        press(0);
        chk("start_count", queue_count, 1);
        chk("start_running", running, 1);
        chk("start_dir", dir, 1);
        do_tick();
        chk("pop_up_dir", dir, 0);
        chk("pop_up_dc", dir_changed, 1);
        chk("pop_up_count", queue_count, 0);
        cyc();
        chk("dc_one_pulse", dir_changed, 0);

        press(2);
        chk("rev_down_count", queue_count, 0);
        press(1);
        do_tick();
        chk("pop_right_dir", dir, 1);
        press(3);
        chk("rev_left_count", queue_count, 0);
        press(2);
        chk("down_count", queue_count, 1);
        do_tick();
        chk("pop_down_dir", dir, 2);
        chk("pop_down_dc", dir_changed, 1);
        cyc();
        chk("pop_down_dc_off", dir_changed, 0);

        press(1);
        do_tick();
        chk("back_right_dir", dir, 1);
        press(0);
        press(3);
        chk("fill_count", queue_count, 2);
        btn_down = 1'b1;
        cyc();
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", queue_count, 2);
        btn_down = 1'b0;
        cyc();
        chk("ovf_off", overflow, 0);
        do_tick();
        chk("drain1_dir", dir, 0);
        do_tick();
        chk("drain2_dir", dir, 3);
        chk("drain_count", queue_count, 0);
        cyc();
        do_tick();
        chk("empty_tick_dir", dir, 3);
        chk("empty_tick_dc", dir_changed, 0);

        btn_up = 1'b1; btn_left = 1'b1;
        cyc();
        btn_up = 1'b0; btn_left = 1'b0;
        cyc();
        chk("multi_rise_count", queue_count, 1);
        tick = 1'b1; btn_down = 1'b1;
        cyc();
        tick = 1'b0; btn_down = 1'b0;
        chk("tick_rev_dir", dir, 0);
        chk("tick_rev_count", queue_count, 0);
        chk("tick_rev_dc", dir_changed, 1);
        cyc();

        press(1);
        press(2);
        chk("refill_count", queue_count, 2);
        tick = 1'b1; btn_left = 1'b1;
        cyc();
        tick = 1'b0; btn_left = 1'b0;
        chk("full_tick_push_dir", dir, 1);
        chk("full_tick_push_count", queue_count, 2);
        chk("full_tick_push_ovf", overflow, 0);
        cyc();
        do_tick();
        chk("pop_after_dir", dir, 2);
        chk("pop_after_count", queue_count, 1);
        press(0);
        chk("pre_go_count", queue_count, 2);
        game_over = 1'b1; tick = 1'b1;
        cyc();
        game_over = 1'b0; tick = 1'b0;
        chk("go_count", queue_count, 0);
        chk("go_dir", dir, 1);
        chk("go_running", running, 0);
        chk("go_dc", dir_changed, 0);
        do_tick();
        chk("idle_tick_dir", dir, 1);
        chk("idle_tick_dc", dir_changed, 0);
        cyc();

`ifdef PAUSE_KEY_EN
        press(0);
        chk("p_start_running", running, 1);
        do_tick();
        chk("p_pop_dir", dir, 0);
        btn_pause = 1'b1; cyc(); btn_pause = 1'b0; cyc();
        chk("p_on", paused, 1);
        press(1);
        chk("p_drop_count", queue_count, 0);
        chk("p_drop_ovf", overflow, 0);
        do_tick();
        chk("p_tick_dir", dir, 0);
        chk("p_tick_dc", dir_changed, 0);
        btn_pause = 1'b1; cyc(); btn_pause = 1'b0; cyc();
        chk("p_off", paused, 0);
        press(1);
        chk("p_resume_count", queue_count, 1);
        do_tick();
        chk("p_resume_dir", dir, 1);
        chk("p_resume_dc", dir_changed, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Downstream consumer of the per-button debouncers. Takes four clean direction-button levels and detects rising edges.
- Rejects illegal moves, meaning no-op or 180° reversal, and buffers accepted moves in a small FIFO.
- On each game-step tick, applies the oldest buffered move to the snake's direction.
- Also tracks the IDLE/RUN game-start state for the snake game core.

Parameters:
- DEPTH, 2, direction-queue depth in entries (1..4).
- INIT_DIR, 2'd1, direction loaded on reset and on game_over (encoding: 0 up, 1 right, 2 down, 3 left).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_up  in  1  debounced up button level.
- btn_right  in  1  debounced right button level.
- btn_down  in  1  debounced down button level.
- btn_left  in  1  debounced left button level.
- tick  in  1  one-cycle game-step pulse from game core.
- game_over  in  1  one-cycle pulse; return to IDLE.
- dir  out  2  current applied direction.
- dir_changed  out  1  one-cycle pulse when dir is updated from the queue.
- running  out  1  high in RUN state.
- queue_count  out  3  number of buffered moves.
- overflow  out  1  one-cycle pulse when an accepted-legal move is dropped because the queue is full.
- paused  out  1  pause state; tied 0 unless PAUSE_KEY_EN is defined.

Behaviour:
- Reset values: every output register cleared asynchronously. Specifically: dir=INIT_DIR, dir_changed=0, running=0, queue_count=0, overflow=0, paused=0, edge registers=0, state=IDLE.
- Edge detect: prev registers hold last-cycle button levels; rise = btn & ~prev. A button held at reset release does not count as an edge until it is released and pressed again.
- Same-cycle multiple rises: priority up > right > down > left. Only one candidate move per cycle; the others are discarded silently.
- Legality reference: the queue tail if queue_count>0, otherwise dir.
  - Candidate equal to the reference: dropped silently.
  - Candidate equal to reference^2 (reversal): dropped silently.
- Push: a legal candidate is written at the tail; queue_count increments. If the queue is full, the candidate is dropped and overflow pulses for 1 cycle.
- Pop: on tick in RUN with queue_count>0, the head is loaded into dir and dir_changed pulses in the next cycle (1-cycle latency). A tick with an empty queue has no effect and leaves dir unchanged.
- Simultaneous tick and push:
  - Pop is applied first, then the push.
  - The legality reference is the pre-pop tail, or dir if the queue was empty.
  - The count is unchanged when both succeed.
  - A full queue plus tick is not an overflow.
- FSM:
  - IDLE: ticks ignored. The first legal candidate is enqueued and the state moves to RUN in the same cycle. Illegal candidates keep the FSM in IDLE.
  - RUN: normal operation.
  - game_over in any state, taking priority over tick and push that cycle: flush queue (count=0), dir=INIT_DIR, state=IDLE, paused=0.
- Queue storage: DEPTH×2-bit circular buffer with wrapping read/write pointers. queue_count is a separate counter; full = (count==DEPTH).
- running = (state==RUN), registered.

Optional Feature:
- Macro name: PAUSE_KEY_EN.
- Defined:
  - Adds input btn_pause (1 bit, debounced).
  - A rising edge in RUN toggles paused; edges in IDLE are ignored.
  - While paused=1: ticks do not pop, direction candidates are dropped (no overflow), and game_over still clears paused.
- Undefined: no btn_pause port; paused is held at 0.

Test Plan:
- Reset release with btn_right held high → no enqueue, running=0, dir=1, queue_count=0; release then press right → still IDLE (equal to dir, illegal); press up → queue_count=1, running=1.
- In RUN with dir=1: press left (reversal) → dropped, queue_count stays 0; press down, then tick → dir=2 next cycle, dir_changed pulses once.
- DEPTH=2, dir=1, no ticks: press up, left, down in turn → first two queued, third asserts overflow for 1 cycle; tick, tick → dir goes 0, then 3.
- Same-cycle rise on up and left with dir=1 → only up is queued (count=1). Tick coincident with a down press when the queue holds [up] → dir=0, queue=[down]... down versus pre-pop tail up is a reversal, so it is dropped and count=0.
- game_over while queue_count=2 and dir=0 → next cycle: count=0, dir=1, running=0, dir_changed=0.
- With PAUSE_KEY_EN: in RUN press pause → paused=1; ticks leave dir unchanged and a down press is dropped; press pause again → paused=0 and normal pops resume.
